// File: rtl/comm_pkg.sv
// Shared definitions for the 3-byte serial command link (master FSM states,
// response codes, field widths).
package comm_pkg;

  localparam int unsigned CMD_W  = 24;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] POS_ACK = 8'hA5;
  localparam logic [BYTE_W-1:0] NEG_ACK = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    TX_HI,
    TX_MID,
    TX_LO,
    WAIT_RESP
  } state_t;

endpackage

// File: rtl/comm_master_if.sv
// Host-side command/response bundle of comm_master.
interface comm_master_if;
  import comm_pkg::*;

  logic                snd_cmd;
  logic [CMD_W-1:0]    cmd;
  logic                clr_resp_rdy;
  logic                busy;
  logic                cmd_cmplt;
  logic                resp_rdy;
  logic [BYTE_W-1:0]   resp;
  logic                timeout;

  modport master (
    input  snd_cmd, cmd, clr_resp_rdy,
    output busy, cmd_cmplt, resp_rdy, resp, timeout
  );

  modport slave (
    output snd_cmd, cmd, clr_resp_rdy,
    input  busy, cmd_cmplt, resp_rdy, resp, timeout
  );

endinterface

// File: rtl/UART.sv
// 8N1 UART transceiver; BAUD_DIV clocks per bit. tx_done clears on trmt,
// rdy clears on clr_rdy.
module UART
  import comm_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              TX,
  input  logic              trmt,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_done,
  output logic              rdy,
  output logic [BYTE_W-1:0] rx_data,
  input  logic              clr_rdy
);

  localparam int unsigned      CNT_W    = 16;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(BAUD_DIV / 2 - 1);

  logic [9:0]        tx_shift_q;
  logic [CNT_W-1:0]  tx_cnt_q;
  logic [3:0]        tx_bit_q;
  logic              tx_busy_q;
  logic              tx_done_q;

  logic              rx_s1_q, rx_s2_q;
  logic [CNT_W-1:0]  rx_cnt_q;
  logic [3:0]        rx_bit_q;
  logic              rx_busy_q;
  logic [BYTE_W-1:0] rx_shift_q;
  logic [BYTE_W-1:0] rx_data_q;
  logic              rdy_q;

  // Transmitter: {stop, data, start} shifted out LSB first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= '1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b0;
      tx_done_q  <= 1'b0;
    end else if (trmt) begin
      tx_shift_q <= {1'b1, tx_data, 1'b0};
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_busy_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_LAST) begin
        tx_cnt_q   <= '0;
        tx_shift_q <= {1'b1, tx_shift_q[9:1]};
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
          tx_done_q <= 1'b1;
        end else begin
          tx_bit_q <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q + CNT_W'(1);
      end
    end
  end

  // Receiver: synchronise, sample mid-bit, reject false starts and bad stops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_busy_q  <= 1'b0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
      if (clr_rdy) rdy_q <= 1'b0;
      if (!rx_busy_q) begin
        if (!rx_s2_q) begin
          rx_busy_q <= 1'b1;
          rx_cnt_q  <= BIT_HALF;
          rx_bit_q  <= '0;
        end
      end else if (rx_cnt_q != '0) begin
        rx_cnt_q <= rx_cnt_q - CNT_W'(1);
      end else begin
        rx_cnt_q <= BIT_LAST;
        if (rx_bit_q == 4'd0) begin
          if (rx_s2_q) rx_busy_q <= 1'b0;
          else         rx_bit_q  <= 4'd1;
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          if (rx_s2_q) begin
            rx_data_q <= rx_shift_q;
            rdy_q     <= 1'b1;
          end
        end else begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[BYTE_W-1:1]};
          rx_bit_q   <= rx_bit_q + 4'd1;
        end
      end
    end
  end

  assign TX      = tx_shift_q[0];
  assign tx_done = tx_done_q;
  assign rdy     = rdy_q;
  assign rx_data = rx_data_q;

endmodule

// File: rtl/comm_master.sv
// Command-issuing end of the 3-byte serial link: sends cmd MSB-byte first,
// then waits for a one-byte response. COMM_MASTER_TIMEOUT_EN adds a response timeout.
module comm_master
  import comm_pkg::*;
#(
  parameter int unsigned      BAUD_DIV     = 434,
  parameter logic [CMD_W-1:0] RESP_TIMEOUT = 24'd1_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          RX,
  output logic          TX,
  comm_master_if.master bus
);

  state_t            state_q, state_d;
  logic [CMD_W-1:0]  cmd_shdw_q, cmd_shdw_d;
  logic [BYTE_W-1:0] resp_q, resp_d;
  logic              resp_rdy_q, resp_rdy_d;
  logic              timeout_q, timeout_d;
  logic              cmd_cmplt_q, cmd_cmplt_d;
  logic              busy_q;

  logic              trmt_c;
  logic [BYTE_W-1:0] tx_data_c;
  logic              clr_rdy_c;
  logic              expired_c;
  logic              tx_done;
  logic              rdy;
  logic [BYTE_W-1:0] rx_data;

  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .TX      (TX),
    .trmt    (trmt_c),
    .tx_data (tx_data_c),
    .tx_done (tx_done),
    .rdy     (rdy),
    .rx_data (rx_data),
    .clr_rdy (clr_rdy_c)
  );

`ifdef COMM_MASTER_TIMEOUT_EN
  logic [CMD_W-1:0] tmo_cnt_q;

  // Counts cycles spent in WAIT_RESP; zero everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     tmo_cnt_q <= '0;
    else if (state_q == WAIT_RESP)  tmo_cnt_q <= tmo_cnt_q + CMD_W'(1);
    else                            tmo_cnt_q <= '0;
  end

  assign expired_c = (tmo_cnt_q == RESP_TIMEOUT - CMD_W'(1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^RESP_TIMEOUT;
  assign expired_c      = 1'b0;
`endif

  logic unused_shdw_hi;
  assign unused_shdw_hi = ^cmd_shdw_q[CMD_W-1:CMD_W-BYTE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_shdw_q  <= '0;
      resp_q      <= '0;
      resp_rdy_q  <= 1'b0;
      timeout_q   <= 1'b0;
      cmd_cmplt_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_shdw_q  <= cmd_shdw_d;
      resp_q      <= resp_d;
      resp_rdy_q  <= resp_rdy_d;
      timeout_q   <= timeout_d;
      cmd_cmplt_q <= cmd_cmplt_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  // Next state plus Mealy trmt/clr_rdy; any received byte is acknowledged at once
  always_comb begin
    state_d     = state_q;
    cmd_shdw_d  = cmd_shdw_q;
    resp_d      = resp_q;
    resp_rdy_d  = resp_rdy_q & ~bus.clr_resp_rdy;
    timeout_d   = timeout_q;
    cmd_cmplt_d = 1'b0;
    trmt_c      = 1'b0;
    tx_data_c   = cmd_shdw_q[15:8];
    clr_rdy_c   = rdy;
    case (state_q)
      IDLE: begin
        if (bus.snd_cmd) begin
          cmd_shdw_d = bus.cmd;
          trmt_c     = 1'b1;
          tx_data_c  = bus.cmd[23:16];
          resp_rdy_d = 1'b0;
          timeout_d  = 1'b0;
          state_d    = TX_HI;
        end
      end
      TX_HI: begin
        if (tx_done) begin
          trmt_c    = 1'b1;
          tx_data_c = cmd_shdw_q[15:8];
          state_d   = TX_MID;
        end
      end
      TX_MID: begin
        tx_data_c = cmd_shdw_q[7:0];
        if (tx_done) begin
          trmt_c  = 1'b1;
          state_d = TX_LO;
        end
      end
      TX_LO: begin
        if (tx_done) begin
          cmd_cmplt_d = 1'b1;
          state_d     = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (rdy) begin
          resp_d     = rx_data;
          resp_rdy_d = 1'b1;
          state_d    = IDLE;
        end else if (expired_c) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = busy_q;
  assign bus.cmd_cmplt = cmd_cmplt_q;
  assign bus.resp_rdy  = resp_rdy_q;
  assign bus.resp      = resp_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_comm_master.sv
// Scoreboard bench for comm_master: a behavioural far end decodes TX and drives RX.
module tb_comm_master;
  import comm_pkg::*;

  localparam int unsigned BAUD_DIV = 8;
  localparam int unsigned FRAME    = 10 * BAUD_DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic RX = 1'b1;
  logic TX;

  comm_master_if bus();

  comm_master #(.BAUD_DIV(BAUD_DIV), .RESP_TIMEOUT(24'd1000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .RX    (RX),
    .TX    (TX),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int epoch = 0;
  int cmds_rx = 0;
  int cmplt_cnt = 0;
  logic [23:0] exp_cmd_q[$];
  logic [7:0]  exp_resp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got %0h expected none", name, act);
  endtask

  // Far end receiver: decode 8N1 frames, assemble 3-byte commands, score them
  initial begin : far_end
    logic [7:0]  b;
    logic [23:0] acc;
    int ep;
    int n;
    int acc_ep;
    b = '0; acc = '0; n = 0; acc_ep = 0;
    forever begin
      @(negedge clk);
      if (rst_n && TX === 1'b0) begin
        ep = epoch;
        repeat (BAUD_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD_DIV) @(negedge clk);
          b[i] = TX;
        end
        repeat (BAUD_DIV) @(negedge clk);
        if (ep == epoch) begin
          chk("stop_bit", 32'(TX), 32'd1);
          if (acc_ep != epoch) begin
            n = 0;
            acc_ep = epoch;
          end
          acc = {acc[15:0], b};
          n++;
          if (n == 3) begin
            n = 0;
            cmds_rx++;
            if (exp_cmd_q.size() == 0) fail("far_cmd_unexpected", 32'(acc));
            else chk("far_cmd", 32'(acc), 32'(exp_cmd_q.pop_front()));
          end
        end
      end
    end
  end

  // Response monitor: every rising resp_rdy must match the next expected byte
  initial begin : resp_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.resp_rdy === 1'b1 && !prev) begin
        if (exp_resp_q.size() == 0) fail("resp_unexpected", 32'(bus.resp));
        else chk("resp_sb", 32'(bus.resp), 32'(exp_resp_q.pop_front()));
      end
      prev = (bus.resp_rdy === 1'b1);
    end
  end

  initial begin : cmplt_mon
    forever begin
      @(negedge clk);
      if (bus.cmd_cmplt === 1'b1) cmplt_cnt++;
    end
  end

  task automatic send_cmd(input logic [23:0] c, input bit expect_it);
    @(negedge clk);
    bus.cmd = c;
    bus.snd_cmd = 1'b1;
    if (expect_it) exp_cmd_q.push_back(c);
    @(negedge clk);
    bus.snd_cmd = 1'b0;
    bus.cmd = 24'h0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    RX = 1'b0;
    repeat (BAUD_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BAUD_DIV) @(negedge clk);
    end
    RX = 1'b1;
    repeat (BAUD_DIV) @(negedge clk);
  endtask

  task automatic wait_cmplt(input string name);
    int c0;
    bit seen;
    c0 = cmplt_cnt;
    seen = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (bus.cmd_cmplt === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail({name, "_cmplt_timeout"}, 32'(cmplt_cnt));
    chk({name, "_busy_at_cmplt"}, 32'(bus.busy), 32'd1);
    repeat (3) @(negedge clk);
    chk({name, "_cmplt_single"}, 32'(cmplt_cnt), 32'(c0 + 1));
  endtask

  task automatic respond(input logic [7:0] b, input string name);
    exp_resp_q.push_back(b);
    send_rx(b);
    repeat (3) @(negedge clk);
    chk({name, "_resp"}, 32'(bus.resp), 32'(b));
    chk({name, "_resp_rdy"}, 32'(bus.resp_rdy), 32'd1);
    chk({name, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    chk({name, "_cmplt"}, 32'(bus.cmd_cmplt), 32'd0);
    chk({name, "_resp_rdy"}, 32'(bus.resp_rdy), 32'd0);
    chk({name, "_resp"}, 32'(bus.resp), 32'h00);
    chk({name, "_timeout"}, 32'(bus.timeout), 32'd0);
    chk({name, "_tx"}, 32'(TX), 32'd1);
  endtask

  initial begin : stim
    int c_before;
    bus.snd_cmd = 1'b0;
    bus.cmd = 24'h0;
    bus.clr_resp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic command, then positive acknowledge
    send_cmd(24'h123456, 1'b1);
    chk("t1_busy_rise", 32'(bus.busy), 32'd1);
    wait_cmplt("t1");
    respond(POS_ACK, "t1");
    @(negedge clk);
    bus.clr_resp_rdy = 1'b1;
    @(negedge clk);
    bus.clr_resp_rdy = 1'b0;
    chk("t1_clr_resp_rdy", 32'(bus.resp_rdy), 32'd0);
    chk("t1_resp_kept", 32'(bus.resp), 32'hA5);

    // Second request during TX_MID must be ignored
    c_before = cmds_rx;
    send_cmd(24'hABCDEF, 1'b1);
    repeat (FRAME + 3 * BAUD_DIV) @(negedge clk);
    send_cmd(24'h000000, 1'b0);
    wait_cmplt("t3");
    repeat (FRAME + 2 * BAUD_DIV) @(negedge clk);
    chk("t3_one_cmd", 32'(cmds_rx), 32'(c_before + 1));
    respond(NEG_ACK, "t3");

    // Reset during TX_MID, then a clean command
    send_cmd(24'h0F0F0F, 1'b0);
    repeat (FRAME + 3 * BAUD_DIV) @(negedge clk);
    rst_n = 1'b0;
    epoch++;
    @(negedge clk);
    check_reset_vals("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    send_cmd(24'h5A5A5A, 1'b1);
    wait_cmplt("t4");
    respond(POS_ACK, "t4");
    @(negedge clk);
    bus.clr_resp_rdy = 1'b1;
    @(negedge clk);
    bus.clr_resp_rdy = 1'b0;

    // Unsolicited byte in IDLE is dropped
    send_rx(NEG_ACK);
    repeat (3) @(negedge clk);
    chk("unsol_resp_rdy", 32'(bus.resp_rdy), 32'd0);
    chk("unsol_resp", 32'(bus.resp), 32'hA5);
    chk("unsol_uart_rdy", 32'(dut.u_uart.rdy), 32'd0);
    chk("unsol_busy", 32'(bus.busy), 32'd0);

`ifdef COMM_MASTER_TIMEOUT_EN
    send_cmd(24'h010203, 1'b1);
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (bus.cmd_cmplt === 1'b1) break;
    end
    repeat (999) @(negedge clk);
    chk("tmo_early", 32'(bus.timeout), 32'd0);
    @(negedge clk);
    chk("tmo_set", 32'(bus.timeout), 32'd1);
    chk("tmo_busy", 32'(bus.busy), 32'd0);
    chk("tmo_resp_rdy", 32'(bus.resp_rdy), 32'd0);
    repeat (2 * FRAME) @(negedge clk);
    send_cmd(24'h040506, 1'b1);
    chk("tmo_cleared", 32'(bus.timeout), 32'd0);
    wait_cmplt("tmo2");
    respond(POS_ACK, "tmo2");
`endif

    repeat (FRAME) @(negedge clk);
    chk("cmd_q_drained", 32'(exp_cmd_q.size()), 32'd0);
    chk("resp_q_drained", 32'(exp_resp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
